fpu_dispatch_array: RTL and testbench
=====================================

FPU_DISPATCH_ARRAY -- requirements
Module: fpu_dispatch_array

Interface
REQ-001 The block SHALL have the following parameters.
- NUM_CORES, default 4: number of attached FP cores; power of 2, minimum 2.
- FIFO_DEPTH, default 8: job FIFO entries; power of 2, minimum 2.
- DW, default 32: operand/result width.
REQ-002 The block SHALL have the following ports (name, direction, width, meaning).
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  dispatch enable.
- in_valid  in  1  job offered.
- in_ready  out  1  job accepted when high with in_valid.
- in_a, in_b, in_c, in_d  in  DW each  job operands.
- core_start  out  NUM_CORES  one-hot start pulse, one bit per core.
- core_a, core_b, core_c, core_d  out  DW each  shared operand bus, valid while any core_start bit is high.
- core_done  in  NUM_CORES  per-core one-cycle completion pulse.
- core_g  in  NUM_CORES*DW  per-core result; slice k is valid when core_done[k] is high.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts.
- out_g  out  DW  result.
- fifo_count  out  clog2(FIFO_DEPTH)+1  jobs held in the FIFO.
- inflight  out  clog2(NUM_CORES)+1  jobs dispatched but not yet drained.
- err_spurious  out  1  sticky flag: core_done seen on a core that is not busy.

Function
REQ-003 Jobs SHALL be pushed into the FIFO on any clock edge where in_valid&in_ready; in_ready SHALL equal !full and SHALL NOT depend on en.
REQ-004 Dispatch SHALL be strict round-robin: dispatch pointer d_ptr starts at core 0 and advances by 1 modulo NUM_CORES after each dispatch.
REQ-005 Each core k SHALL be in exactly one state.
- IDLE -> BUSY on dispatch.
- BUSY -> HELD on core_done[k]; core_g slice k is captured into a per-core result register.
- HELD -> IDLE when its result is drained.
REQ-006 A pop/dispatch SHALL occur at a clock edge where en=1, FIFO is non-empty and core d_ptr is IDLE; there SHALL be at most one dispatch per cycle.
REQ-007 core_start[d_ptr] and core_a..core_d SHALL be registered: they are high/valid for exactly the one cycle following the dispatch edge, and zero otherwise.
REQ-008 The minimum latency from the accept edge to core_start high SHALL be 2 cycles, with no FIFO bypass.
REQ-009 Results SHALL be delivered in job-acceptance order via output pointer o_ptr, which starts at 0 and advances modulo NUM_CORES.
- out_valid = (core o_ptr is HELD).
- out_g = result register of core o_ptr.
- Both SHALL be combinational from registered state.
REQ-010 A drain SHALL occur on out_valid&out_ready; the core returns to IDLE and o_ptr increments at that edge.
- out_valid and out_g SHALL remain stable until drained.
REQ-011 A HELD core SHALL block its own redispatch but SHALL NOT block dispatch decisions for other cores; dispatch still waits on d_ptr only.
REQ-012 core_done[k] while core k is not BUSY SHALL be ignored (no capture, no state change) and SHALL set err_spurious.
- err_spurious SHALL be cleared only by reset.
REQ-013 Multiple core_done bits in one cycle SHALL all be captured.
REQ-014 A dispatch, a drain, and any number of done pulses SHALL all be honoured in the same cycle, including on the same core when the states permit.
REQ-015 fifo_count SHALL be +1 on push, -1 on pop, and unchanged on simultaneous push and pop.
REQ-016 inflight SHALL be +1 on dispatch, -1 on drain, and range 0..NUM_CORES.
REQ-017 When en=0, dispatch SHALL stall; pushes, core_done capture and drains SHALL continue.

Reset
REQ-018 While rst=0, the block SHALL clear the following state.
- FIFO empty; d_ptr and o_ptr = 0.
- All cores IDLE; result registers = 0.
- core_start = 0; core_a..core_d = 0.
- out_valid = 0; out_g = 0.
- fifo_count = 0; inflight = 0; err_spurious = 0.
- in_ready = 1.
REQ-019 Reset mid-operation SHALL discard all queued and in-flight jobs.
- core_done pulses while rst=0 SHALL be ignored.
- A core_done arriving after reset release for a pre-reset job SHALL be flagged per REQ-012.

Verification
REQ-020 The bench SHALL cover the following directed scenarios with models of NUM_CORES=4 cores.
- Single job: a=0x3F800000, accept at cycle 0 -> core_start=4'b0001 at cycle 2 with core_a=0x3F800000; model done at cycle 5 with g=0x40000000 -> out_valid=1, out_g=0x40000000 at cycle 6; inflight returns to 0 after drain.
- Out-of-order completion: jobs J0..J3 done in order 3,1,2,0 -> out_g emitted in order J0,J1,J2,J3, with out_valid low until core0 done.
- Backpressure and full FIFO: en=0, push 8 jobs -> in_ready=0 with fifo_count=8; 9th in_valid not accepted; set en=1 -> start bits 0001, 0010, 0100, 1000 on consecutive cycles.
- Held-core block: 5 jobs, out_ready=0, all cores done -> job 5 not dispatched; one drain -> core_start=4'b0001 two cycles later.
- Spurious done: core_done[2] while core 2 is IDLE -> err_spurious=1 and stays 1; no out_valid.
- Reset mid-run: rst=0 with 3 jobs in flight and 2 queued -> all outputs at reset values; a post-release done on core 0 -> err_spurious=1 and out_valid stays 0.

Source files
------------

// File: rtl/fpu_dispatch_array.sv
// fpu_dispatch_array: job FIFO feeding NUM_CORES FP cores round-robin,
// results held per core and returned in job-acceptance order.
module fpu_dispatch_array #(
  parameter int NUM_CORES  = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int DW         = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DW-1:0]                   in_a,
  input  logic [DW-1:0]                   in_b,
  input  logic [DW-1:0]                   in_c,
  input  logic [DW-1:0]                   in_d,
  output logic [NUM_CORES-1:0]            core_start,
  output logic [DW-1:0]                   core_a,
  output logic [DW-1:0]                   core_b,
  output logic [DW-1:0]                   core_c,
  output logic [DW-1:0]                   core_d,
  input  logic [NUM_CORES-1:0]            core_done,
  input  logic [NUM_CORES*DW-1:0]         core_g,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DW-1:0]                   out_g,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic [$clog2(NUM_CORES):0]      inflight,
  output logic                            err_spurious
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = $clog2(NUM_CORES);
  localparam int CW = AW + 1;
  localparam int IW = PW + 1;

  typedef enum logic [1:0] {
    C_IDLE,
    C_BUSY,
    C_HELD
  } core_st_e;

  logic [4*DW-1:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr;
  logic [AW-1:0]        r_rd;
  logic [CW-1:0]        r_cnt;
  logic [PW-1:0]        r_dptr;
  logic [PW-1:0]        r_optr;
  logic [IW-1:0]        r_infl;
  core_st_e             r_st [NUM_CORES];
  core_st_e             w_st_nx [NUM_CORES];
  logic [DW-1:0]        r_res [NUM_CORES];
  logic [NUM_CORES-1:0] w_cap;
  logic                 w_spur;
  logic [NUM_CORES-1:0] r_start;
  logic [DW-1:0]        r_a;
  logic [DW-1:0]        r_b;
  logic [DW-1:0]        r_c;
  logic [DW-1:0]        r_d;
  logic                 r_err;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_drain;
  logic                 w_full;
  logic                 w_empty;
  logic [4*DW-1:0]      w_head;
  logic [NUM_CORES-1:0] w_one;

  assign w_one   = {{(NUM_CORES-1){1'b0}}, 1'b1};
  assign w_full  = (r_cnt == CW'(FIFO_DEPTH));
  assign w_empty = (r_cnt == '0);
  assign w_push  = in_valid && !w_full;
  assign w_pop   = en && !w_empty && (r_st[r_dptr] == C_IDLE);
  assign w_drain = out_valid && out_ready;
  assign w_head  = r_mem[r_rd];

  // job storage; reads are gated by the count so no reset is needed
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= {in_a, in_b, in_c, in_d};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // per-core next state; dispatch, done and drain never hit one state
  always_comb begin
    w_cap  = '0;
    w_spur = 1'b0;
    for (int k = 0; k < NUM_CORES; k++) begin
      w_st_nx[k] = r_st[k];
      if (core_done[k]) begin
        if (r_st[k] == C_BUSY) begin
          w_st_nx[k] = C_HELD;
          w_cap[k]   = 1'b1;
        end else begin
          w_spur = 1'b1;
        end
      end
      if (w_pop && r_dptr == PW'(k))
        w_st_nx[k] = C_BUSY;
      if (w_drain && r_optr == PW'(k))
        w_st_nx[k] = C_IDLE;
    end
  end

  // per-core state and result capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_CORES; k++) begin
        r_st[k]  <= C_IDLE;
        r_res[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CORES; k++) begin
        r_st[k] <= w_st_nx[k];
        if (w_cap[k]) r_res[k] <= core_g[k*DW +: DW];
      end
    end
  end

  // dispatch/output pointers, in-flight count, sticky error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dptr <= '0;
      r_optr <= '0;
      r_infl <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_pop)   r_dptr <= r_dptr + 1'b1;
      if (w_drain) r_optr <= r_optr + 1'b1;
      case ({w_pop, w_drain})
        2'b10:   r_infl <= r_infl + 1'b1;
        2'b01:   r_infl <= r_infl - 1'b1;
        default: r_infl <= r_infl;
      endcase
      if (w_spur) r_err <= 1'b1;
    end
  end

  // one-cycle start pulse with operands, zero when idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_start <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_d     <= '0;
    end else if (w_pop) begin
      r_start <= w_one << r_dptr;
      {r_a, r_b, r_c, r_d} <= w_head;
    end else begin
      r_start <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_d     <= '0;
    end
  end

  assign in_ready     = !w_full;
  assign core_start   = r_start;
  assign core_a       = r_a;
  assign core_b       = r_b;
  assign core_c       = r_c;
  assign core_d       = r_d;
  assign out_valid    = (r_st[r_optr] == C_HELD);
  assign out_g        = r_res[r_optr];
  assign fifo_count   = r_cnt;
  assign inflight     = r_infl;
  assign err_spurious = r_err;

endmodule

// File: tb/tb_fpu_dispatch_array.sv
// tb_fpu_dispatch_array: directed scenarios and random traffic checked
// against a job-level model (counts of accepted/dispatched/drained jobs).
module tb_fpu_dispatch_array;

  localparam int N  = 4;
  localparam int D  = 8;
  localparam int DW = 32;
  localparam int MJ = 8192;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_a, in_b, in_c, in_d;
  logic [N-1:0]    core_start;
  logic [DW-1:0]   core_a, core_b, core_c, core_d;
  logic [N-1:0]    core_done;
  logic [N*DW-1:0] core_g;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_g;
  logic [3:0]      fifo_count;
  logic [2:0]      inflight;
  logic            err_spurious;

  fpu_dispatch_array #(
    .NUM_CORES(N), .FIFO_DEPTH(D), .DW(DW)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
    .core_start(core_start),
    .core_a(core_a), .core_b(core_b),
    .core_c(core_c), .core_d(core_d),
    .core_done(core_done), .core_g(core_g),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_g(out_g), .fifo_count(fifo_count),
    .inflight(inflight), .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // job-level model: jobs numbered in acceptance order
  logic [DW-1:0] ja [MJ];
  logic [DW-1:0] jb [MJ];
  logic [DW-1:0] jc [MJ];
  logic [DW-1:0] jd [MJ];
  logic [DW-1:0] jg [MJ];
  bit            jdn [MJ];
  int            acc, disp, drn;
  logic [N-1:0]  e_start;
  logic [DW-1:0] e_a, e_b, e_c, e_d, e_og;
  bit            e_ov, e_err;

  // core models
  bit   cb [N];
  int   cj [N];
  int   cc [N];
  int   pj [N];
  bit   auto_done;
  logic [N-1:0] dn;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // drive one cycle from a negedge, predict the edge, check at next negedge
  task automatic cyc();
    bit push, pop, drain;
    if (auto_done)
      for (int k = 0; k < N; k++)
        if (cb[k]) begin
          if (cc[k] == 0) dn[k] = 1'b1;
          else cc[k]--;
        end
    for (int k = 0; k < N; k++)
      core_g[k*DW +: DW] = (dn[k] && cb[k]) ? jg[cj[k]] : $urandom;
    core_done = dn;
    push  = in_valid && (acc - disp < D);
    pop   = en && (acc - disp > 0) && (disp - drn < N);
    drain = e_ov && out_ready;
    for (int k = 0; k < N; k++)
      if (dn[k]) begin
        if (cb[k]) begin
          jdn[cj[k]] = 1'b1;
          cb[k] = 1'b0;
        end else begin
          e_err = 1'b1;
        end
      end
    if (push) begin
      ja[acc] = in_a; jb[acc] = in_b;
      jc[acc] = in_c; jd[acc] = in_d;
      jg[acc] = $urandom; jdn[acc] = 1'b0;
      acc++;
    end
    if (pop) begin
      e_start = N'(1) << (disp % N);
      e_a = ja[disp]; e_b = jb[disp];
      e_c = jc[disp]; e_d = jd[disp];
      pj[disp % N] = disp;
      disp++;
    end else begin
      e_start = '0;
      e_a = '0; e_b = '0; e_c = '0; e_d = '0;
    end
    if (drain) drn++;
    e_ov = (drn < disp) && jdn[drn];
    e_og = jg[drn];
    @(negedge clk);
    dn = '0;
    core_done = '0;
    chk("start", 64'(core_start), 64'(e_start));
    chk("core_a", 64'(core_a), 64'(e_a));
    chk("core_b", 64'(core_b), 64'(e_b));
    chk("core_c", 64'(core_c), 64'(e_c));
    chk("core_d", 64'(core_d), 64'(e_d));
    chk("fifo_count", 64'(fifo_count), 64'(acc - disp));
    chk("inflight", 64'(inflight), 64'(disp - drn));
    chk("in_ready", 64'(in_ready), 64'((acc - disp) < D));
    chk("out_valid", 64'(out_valid), 64'(e_ov));
    if (e_ov) chk("out_g", 64'(out_g), 64'(e_og));
    chk("err", 64'(err_spurious), 64'(e_err));
    for (int k = 0; k < N; k++)
      if (core_start[k]) begin
        cb[k] = 1'b1;
        cj[k] = pj[k];
        cc[k] = $urandom_range(0, 5);
      end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; en = 1'b1;
    in_a = '0; in_b = '0; in_c = '0; in_d = '0;
    dn = '0;
    core_done = '1;
    core_g = '1;
    #1;
    chk("rst_start", 64'(core_start), 64'd0);
    chk("rst_a", 64'(core_a), 64'd0);
    chk("rst_b", 64'(core_b), 64'd0);
    chk("rst_c", 64'(core_c), 64'd0);
    chk("rst_d", 64'(core_d), 64'd0);
    chk("rst_ov", 64'(out_valid), 64'd0);
    chk("rst_og", 64'(out_g), 64'd0);
    chk("rst_cnt", 64'(fifo_count), 64'd0);
    chk("rst_infl", 64'(inflight), 64'd0);
    chk("rst_err", 64'(err_spurious), 64'd0);
    chk("rst_rdy", 64'(in_ready), 64'd1);
    @(negedge clk);
    core_done = '0;
    @(negedge clk);
    rst = 1'b1;
    acc = 0; disp = 0; drn = 0;
    e_start = '0;
    e_a = '0; e_b = '0; e_c = '0; e_d = '0; e_og = '0;
    e_ov = 1'b0; e_err = 1'b0;
    for (int k = 0; k < N; k++) cb[k] = 1'b0;
  endtask

  task automatic rnd_ops();
    in_a = $urandom; in_b = $urandom;
    in_c = $urandom; in_d = $urandom;
  endtask

  initial begin
    auto_done = 1'b0;
    for (int k = 0; k < N; k++) begin
      cj[k] = 0; cc[k] = 0; pj[k] = 0; cb[k] = 1'b0;
    end
    do_reset();

    // single job, fixed latency
    in_valid = 1'b1;
    in_a = 32'h3F80_0000;
    cyc();
    jg[0] = 32'h4000_0000;
    in_valid = 1'b0; in_a = '0;
    cyc();
    chk("one_start", 64'(core_start), 64'd1);
    chk("one_a", 64'(core_a), 64'h3F80_0000);
    repeat (3) cyc();
    dn = 4'b0001;
    cyc();
    chk("one_ov", 64'(out_valid), 64'd1);
    chk("one_og", 64'(out_g), 64'h4000_0000);
    out_ready = 1'b1;
    cyc();
    chk("one_infl", 64'(inflight), 64'd0);

    // out-of-order completion, in-order delivery
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; rnd_ops(); cyc();
    end
    in_valid = 1'b0;
    repeat (4) cyc();
    dn = 4'b1000; cyc();
    chk("ooo_wait3", 64'(out_valid), 64'd0);
    dn = 4'b0010; cyc();
    chk("ooo_wait1", 64'(out_valid), 64'd0);
    dn = 4'b0100; cyc();
    chk("ooo_wait2", 64'(out_valid), 64'd0);
    dn = 4'b0001; cyc();
    for (int i = 0; i < 4; i++) begin
      chk("ooo_order", 64'(out_g), 64'(jg[i]));
      cyc();
    end
    chk("ooo_infl", 64'(inflight), 64'd0);

    // backpressure with dispatch disabled
    do_reset();
    en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; rnd_ops(); cyc();
    end
    chk("bp_rdy", 64'(in_ready), 64'd0);
    chk("bp_cnt", 64'(fifo_count), 64'd8);
    in_valid = 1'b1; in_a = 32'hDEAD_BEEF;
    cyc();
    chk("bp_cnt9", 64'(fifo_count), 64'd8);
    in_valid = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("bp_start", 64'(core_start), 64'(4'b0001 << i));
    end

    // held core blocks its own redispatch
    do_reset();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; rnd_ops(); cyc();
    end
    in_valid = 1'b0;
    repeat (3) cyc();
    dn = 4'b1111; cyc();
    repeat (3) cyc();
    chk("held_nostart", 64'(core_start), 64'd0);
    chk("held_q", 64'(fifo_count), 64'd1);
    out_ready = 1'b1; cyc();
    out_ready = 1'b0; cyc();
    chk("held_start", 64'(core_start), 64'd1);

    // spurious done on an idle core
    do_reset();
    dn = 4'b0100; cyc();
    chk("spur_err", 64'(err_spurious), 64'd1);
    chk("spur_ov", 64'(out_valid), 64'd0);
    repeat (3) cyc();
    chk("spur_sticky", 64'(err_spurious), 64'd1);

    // reset with jobs queued and in flight
    do_reset();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; rnd_ops(); cyc();
    end
    in_valid = 1'b0; en = 1'b1;
    repeat (3) cyc();
    en = 1'b0; cyc();
    chk("mid_infl", 64'(inflight), 64'd3);
    chk("mid_q", 64'(fifo_count), 64'd2);
    do_reset();
    dn = 4'b0001; cyc();
    chk("post_err", 64'(err_spurious), 64'd1);
    chk("post_ov", 64'(out_valid), 64'd0);

    // random traffic against the model
    do_reset();
    auto_done = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom % 4) != 0;
      rnd_ops();
      en = ($urandom % 8) != 0;
      if (((i / 200) % 2) == 1) out_ready = ($urandom % 4) == 0;
      else out_ready = ($urandom % 4) != 0;
      cyc();
    end
    in_valid = 1'b0; en = 1'b1; out_ready = 1'b1;
    repeat (60) cyc();
    chk("rnd_drained", 64'(inflight), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
